spi_slave_framed: RTL

//  Parametrised, framed SPI mode-0 slave: one CS-low frame carries a sync byte plus NUM_CH

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_slave_framed.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the framed SPI slave: default sync byte and FSM state encoding.
package spi_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_END    = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous level, with single-clk rise/fall strobes
// taken from the two oldest stages.
module spi_sync_edge #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;

    // Chain resets low so a CS held low across reset never produces a fall strobe,
    // which keeps a frame already in progress from being picked up mid-way.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_q[0] <= 1'b0;
                    else     sync_q[0] <= d_i;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) sync_q[gi] <= 1'b0;
                    else     sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign rise_o =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall_o = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_framed.sv
// Framed SPI mode-0 slave: sync byte + NUM_CH setpoint words in, NUM_CH feedback words out,
// setpoints committed atomically on a well-formed frame, bad frames counted.
module spi_slave_framed
    import spi_pkg::*;
#(
    parameter int         NUM_CH    = 2,
    parameter int         DATA_W    = 16,
    parameter int         RESET_VAL = 256,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SPI_CLK,
    input  logic                     SPI_CS,
    input  logic                     SPI_PICO,
    output logic                     SPI_POCI,
    input  logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic                     wr_valid,
    output logic                     frame_err,
    output logic [7:0]               err_cnt
);

    localparam int BPW   = DATA_W / 8;
    localparam int NB    = 1 + NUM_CH * BPW;
    localparam int TOT_W = NUM_CH * DATA_W;
    localparam int CNT_W = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] NB_C = CNT_W'(NB);
    localparam logic [TOT_W-1:0] RESET_WORDS = {NUM_CH{DATA_W'(RESET_VAL)}};

    // Payload byte j (0 = ch0 MSB) lives at this bit offset in the flat word vector.
    function automatic int byte_lsb(input int j);
        return (j / BPW) * DATA_W + (BPW - 1 - (j % BPW)) * 8;
    endfunction

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [1:0] pico_q;

    spi_sync_edge #(.STAGES(3)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(SPI_CLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(3)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(SPI_CS), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               good_q, good_d;
    logic [7:0]         rx_q, rx_d, tx_q, tx_d;
    logic [TOT_W-1:0]   rd_shadow_q, rd_shadow_d, wr_shadow_q, wr_shadow_d;
    logic [TOT_W-1:0]   wr_data_q, wr_data_d;
    logic               wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [7:0]         rx_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            pico_q      <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            good_q      <= 1'b0;
            rx_q        <= '0;
            tx_q        <= '0;
            rd_shadow_q <= '0;
            wr_shadow_q <= RESET_WORDS;
            wr_data_q   <= RESET_WORDS;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            pico_q      <= {pico_q[0], SPI_PICO};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            good_q      <= good_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rd_shadow_q <= rd_shadow_d;
            wr_shadow_q <= wr_shadow_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        good_d      = good_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rd_shadow_d = rd_shadow_q;
        wr_shadow_d = wr_shadow_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        rx_byte     = {rx_q[6:0], pico_q[1]};

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    bit_cnt_d   = '0;
                    byte_cnt_d  = '0;
                    good_d      = 1'b1;
                    rd_shadow_d = rd_data;
                    tx_d        = SYNC_BYTE;
                end
            end
            ST_ACTIVE: begin
                // A CS edge in the same clk as an SCLK edge takes priority.
                if (cs_rise) begin
                    state_d = ST_END;
                end else if (sclk_rise) begin
                    rx_d      = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = (byte_cnt_q == NB_C) ? NB_C : byte_cnt_q + 1'b1;
                        if (byte_cnt_q == '0) begin
                            if (rx_byte != SYNC_BYTE) good_d = 1'b0;
                        end else if (byte_cnt_q == NB_C) begin
                            good_d = 1'b0;
                        end else begin
                            for (int j = 0; j < NB - 1; j++) begin
                                if (byte_cnt_q == CNT_W'(j + 1)) wr_shadow_d[byte_lsb(j) +: 8] = rx_byte;
                            end
                        end
                    end
                end else if (sclk_fall) begin
                    tx_d = {tx_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0 && byte_cnt_q != '0) begin
                        tx_d = 8'h00;
                        for (int j = 0; j < NB - 1; j++) begin
                            if (byte_cnt_q == CNT_W'(j + 1)) tx_d = rd_shadow_q[byte_lsb(j) +: 8];
                        end
                    end
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
                if (good_q && byte_cnt_q == NB_C && bit_cnt_q == 3'd0) begin
                    wr_data_d  = wr_shadow_q;
                    wr_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign SPI_POCI  = (state_q == ST_ACTIVE) & tx_q[7];
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
